// File: rtl/avalon_s_dma.sv
// Single-channel Avalon-MM block copy host: alternating single-word read/write
// with one-word buffering, waitrequest handshaking and abort at access boundaries.
module avalon_s_dma #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int LW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [AW-1:0]     src_addr,
   input  logic [AW-1:0]     dst_addr,
   input  logic [LW-1:0]     length,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              host_avn_read,
   output logic              host_avn_write,
   output logic [AW-1:0]     host_avn_address,
   output logic [DW/8-1:0]   host_avn_byte_enable,
   output logic [DW-1:0]     host_avn_writedata,
   input  logic [DW-1:0]     host_avn_readdata,
   input  logic              host_avn_waitrequest
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] STEP = AW'(DW / 8);

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [DW-1:0] buf_q, buf_d;
   logic          abt_q, abt_d;

   // NOTE: every register, including the data buffer, is cleared by reset so
   // that the bus outputs are defined zeros from the first cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         abt_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
         abt_q   <= abt_d;
      end
   end

   always_comb begin
      // NOTE: hold-by-default assignments first, so no path leaves a latch behind.
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
      abt_d   = abt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = length;
               abt_d   = 1'b0;
               state_d = (length == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (!host_avn_waitrequest) begin
               buf_d = host_avn_readdata;
               if (abort) begin
                  abt_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (!host_avn_waitrequest) begin
               src_d = src_q + STEP;
               dst_d = dst_q + STEP;
               rem_d = rem_q - LW'(1);
               abt_d = abort;
               state_d = (rem_q == LW'(1) || abort) ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            abt_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus and status outputs decode registered state only; nothing from inputs leaks through.
   assign busy                 = (state_q != S_IDLE);
   assign done                 = (state_q == S_DONE);
   assign aborted              = (state_q == S_DONE) && abt_q;
   assign host_avn_read        = (state_q == S_READ);
   assign host_avn_write       = (state_q == S_WRITE);
   assign host_avn_address     = (state_q == S_READ)  ? src_q :
                                 (state_q == S_WRITE) ? dst_q : '0;
   assign host_avn_byte_enable = (state_q == S_READ || state_q == S_WRITE) ? '1 : '0;
   assign host_avn_writedata   = (state_q == S_WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_avalon_s_dma.sv
// Self-checking bench for avalon_s_dma: queue-of-expected-accesses model checked
// every cycle, directed scenarios with literal timing, then randomized traffic.
module tb_avalon_s_dma;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] length;
   logic          busy, done, aborted;
   logic          rd, wr;
   logic [AW-1:0] addr;
   logic [DW/8-1:0] be;
   logic [DW-1:0] wdata, rdata;
   logic          wreq;

   always #5 clk = ~clk;

   avalon_s_dma #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .busy(busy), .done(done), .aborted(aborted),
      .host_avn_read(rd), .host_avn_write(wr),
      .host_avn_address(addr), .host_avn_byte_enable(be),
      .host_avn_writedata(wdata), .host_avn_readdata(rdata),
      .host_avn_waitrequest(wreq)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Slave memory contents: fixed pattern, with the basic-copy words pinned.
   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a >= 32'h1000 && a <= 32'h1008) return 32'hA0 + ((a - 32'h1000) >> 2);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction
   assign rdata = data_of(addr);

   // Waitrequest generator: stalls each access for st_tgt cycles.
   int wait_mode = 0;
   int st_cnt = 0;
   int st_tgt = 0;
   function automatic int new_tgt(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(0, 3));
   endfunction
   initial wreq = 1'b0;
   always @(posedge clk) begin
      #1;
      if (rd || wr) begin
         if (st_cnt < st_tgt) begin
            wreq = 1'b1;
            st_cnt++;
         end else begin
            wreq = 1'b0;
            st_cnt = 0;
            st_tgt = new_tgt(wait_mode);
         end
      end else begin
         wreq = (wait_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         st_cnt = 0;
      end
   end

   // Reference model: queue of bus accesses still owed by the current transfer.
   typedef struct packed {
      logic        is_wr;
      logic [31:0] a;
      logic [31:0] d;
   } acc_t;
   acc_t exp_q[$];
   bit   done_now = 0, abt_now = 0;
   bit   chk_en = 0;

   int          rd_cyc[$], wr_cyc[$];
   logic [31:0] rd_addr[$], wr_addr[$], wr_data[$];
   int          done_cyc = -1;
   logic        done_abt = 1'b0;
   int          busy_cycles = 0;

   task automatic clear_logs();
      rd_cyc.delete(); wr_cyc.delete();
      rd_addr.delete(); wr_addr.delete(); wr_data.delete();
      done_cyc = -1; done_abt = 1'b0; busy_cycles = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         acc_t h;
         bit   nd, na;
         check("done", done, done_now);
         check("aborted", aborted, done_now & abt_now);
         check("busy", busy, (exp_q.size() != 0) || done_now);
         check("rd_wr_excl", rd & wr, 1'b0);
         if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("read", rd, !h.is_wr);
            check("write", wr, h.is_wr);
            check("address", addr, h.a);
            check("byte_enable", be, 4'hF);
            if (h.is_wr) check("writedata", wdata, h.d);
         end else begin
            check("idle_bus", {rd, wr, be, addr, wdata}, '0);
         end

         if (rd && !wreq) begin rd_cyc.push_back(cyc); rd_addr.push_back(addr); end
         if (wr && !wreq) begin
            wr_cyc.push_back(cyc); wr_addr.push_back(addr); wr_data.push_back(wdata);
         end
         if (done) begin done_cyc = cyc; done_abt = aborted; end
         if (busy) busy_cycles++;

         nd = 0; na = 0;
         if (rst) begin
            exp_q.delete();
         end else if (exp_q.size() != 0) begin
            if (!wreq) begin
               void'(exp_q.pop_front());
               if (abort) begin
                  exp_q.delete();
                  nd = 1; na = 1;
               end else if (exp_q.size() == 0) begin
                  nd = 1;
               end
            end
         end else if (!done_now && start) begin
            if (length == 0) nd = 1;
            for (int i = 0; i < int'(length); i++) begin
               logic [31:0] s, t;
               s = src_addr + 32'(4 * i);
               t = dst_addr + 32'(4 * i);
               exp_q.push_back('{is_wr: 1'b0, a: s, d: 32'h0});
               exp_q.push_back('{is_wr: 1'b1, a: t, d: data_of(s)});
            end
         end
         done_now = nd;
         abt_now  = na;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                           input logic [LW-1:0] n, output int t);
      tick();
      start = 1'b1; src_addr = s; dst_addr = d; length = n;
      t = cyc;
      clear_logs();
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL done_timeout cycle=%0d actual=no_done expected=done", cyc);
      end
      tick();
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_status", {busy, done, aborted}, 3'b000);
      check("rst_bus", {rd, wr, be, addr, wdata}, '0);
      chk_en = 1;
      tick();
      rst = 1'b0;

      // Basic copy, zero wait states.
      wait_mode = 0; st_tgt = 0;
      run_xfer(32'h1000, 32'h2000, 3, t);
      wait_done();
      check("basic_done_cyc", done_cyc, t + 7);
      check("basic_busy_cycles", busy_cycles, 7);
      check("basic_nrd", rd_addr.size(), 3);
      check("basic_nwr", wr_addr.size(), 3);
      if (rd_addr.size() == 3 && wr_addr.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check("basic_rd_cyc", rd_cyc[i], t + 1 + 2 * i);
            check("basic_rd_addr", rd_addr[i], 32'h1000 + 32'(4 * i));
            check("basic_wr_cyc", wr_cyc[i], t + 2 + 2 * i);
            check("basic_wr_addr", wr_addr[i], 32'h2000 + 32'(4 * i));
            check("basic_wr_data", wr_data[i], 32'hA0 + 32'(i));
         end
      end

      // One stall cycle on every access: each access takes two cycles.
      wait_mode = 1; st_tgt = 1;
      run_xfer(32'h3000, 32'h4000, 2, t);
      wait_done();
      check("wait_done_cyc", done_cyc, t + 9);
      check("wait_nwr", wr_addr.size(), 2);

      // Zero length.
      wait_mode = 0; st_tgt = 0;
      run_xfer(32'h3000, 32'h4000, 0, t);
      wait_done();
      check("zero_done_cyc", done_cyc, t + 1);
      check("zero_aborted", done_abt, 1'b0);
      check("zero_accesses", rd_addr.size() + wr_addr.size(), 0);
      check("zero_busy_cycles", busy_cycles, 1);

      // Abort during a stalled first write, plus a start while busy.
      wait_mode = 1; st_tgt = 1;
      run_xfer(32'h5000, 32'h6000, 4, t);
      start = 1'b1; length = 7; src_addr = 32'h9000; dst_addr = 32'hA000;
      step_to(t + 2);
      start = 1'b0;
      step_to(t + 3);
      abort = 1'b1;
      wait_done();
      abort = 1'b0;
      check("abort_done_cyc", done_cyc, t + 5);
      check("abort_flag", done_abt, 1'b1);
      check("abort_nwr", wr_addr.size(), 1);
      check("abort_nrd", rd_addr.size(), 1);
      if (wr_addr.size() == 1) check("abort_wr_addr", wr_addr[0], 32'h6000);
      tick();
      check("abort_idle_after", busy, 1'b0);

      // Address wrap, then reset during the second read.
      wait_mode = 0; st_tgt = 0;
      run_xfer(32'hFFFF_FFFC, 32'h0000_0100, 2, t);
      step_to(t + 3);
      rst = 1'b1;
      @(negedge clk);
      check("wrap_rd2_live", {rd, addr}, {1'b1, 32'h0});
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_status", {busy, done, aborted}, 3'b000);
      check("rst_mid_bus", {rd, wr, be, addr, wdata}, '0);
      check("wrap_nrd", rd_addr.size(), 2);
      if (rd_addr.size() == 2) check("wrap_rd_addr", rd_addr[1], 32'h0);
      run_xfer(32'h7000, 32'h8000, 2, t);
      wait_done();
      check("fresh_done_cyc", done_cyc, t + 5);
      check("fresh_abort", done_abt, 1'b0);
      if (wr_data.size() == 2) check("fresh_wr_data", wr_data[1], data_of(32'h7004));
      else check("fresh_nwr", wr_data.size(), 2);

      // Randomized traffic: random stalls, starts, aborts and rare resets.
      wait_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         tick();
         start    = ($urandom_range(0, 5) == 0);
         src_addr = $urandom;
         dst_addr = $urandom;
         length   = LW'($urandom_range(0, 6));
         abort    = ($urandom_range(0, 19) == 0);
         rst      = ($urandom_range(0, 499) == 0);
      end
      tick();
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      repeat (100) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
